// File: rtl/jtflane_pcm_fetch_if.sv
// PCM-side request bus and SDRAM slot bus for jtflane_pcm_fetch.
// The fetch engine uses the master modport and its environment uses the slave modport.
interface jtflane_pcm_fetch_if #(
    parameter int unsigned AW = 17
);
    logic [AW-1:0] pcm_addr;
    logic          pcm_rd;
    logic [7:0]    pcm_dout;
    logic          pcm_valid;
    logic [AW-1:0] rom_addr;
    logic          rom_cs;
    logic [7:0]    rom_data;
    logic          rom_ok;

    modport master (
        input  pcm_addr, pcm_rd, rom_data, rom_ok,
        output pcm_dout, pcm_valid, rom_addr, rom_cs
    );

    modport slave (
        output pcm_addr, pcm_rd, rom_data, rom_ok,
        input  pcm_dout, pcm_valid, rom_addr, rom_cs
    );
endinterface

// File: rtl/jtflane_pcm_fetch.sv
// PCM byte fetcher for an SDRAM slot. It holds a current byte and, when
// JTFLANE_PCM_PREFETCH_EN is defined, a one-byte prefetch of the next address.
module jtflane_pcm_fetch #(
    parameter int unsigned AW    = 17,
    parameter int unsigned GUARD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    jtflane_pcm_fetch_if.master  bus
);
    localparam int unsigned   GW    = $clog2(GUARD + 2);
    localparam logic [GW-1:0] GLOAD = GW'(GUARD);

`ifdef JTFLANE_PCM_PREFETCH_EN
    typedef enum logic [1:0] {StIdle, StFetch, StPref} state_t;
`else
    typedef enum logic [1:0] {StIdle, StFetch} state_t;
`endif

    state_t        r_state, w_state;
    logic [AW-1:0] r_cur_addr, w_cur_addr;
    logic [7:0]    r_cur_data, w_cur_data;
    logic          r_cur_vld, w_cur_vld;
    logic [AW-1:0] r_rom_addr, w_rom_addr;
    logic          r_rom_cs, w_rom_cs;
    logic [GW-1:0] r_guard, w_guard;
`ifdef JTFLANE_PCM_PREFETCH_EN
    logic [AW-1:0] r_pre_addr, w_pre_addr;
    logic [7:0]    r_pre_data, w_pre_data;
    logic          r_pre_vld, w_pre_vld;
`endif

    logic w_hit_cur;
    logic w_ok;
    logic w_miss;

    assign w_hit_cur = r_cur_vld && (bus.pcm_addr == r_cur_addr);
    // rom_ok only counts once the guard window after the last rom_addr load has expired
    assign w_ok      = r_rom_cs && (r_guard == '0) && bus.rom_ok;

    always_comb begin
        w_state    = r_state;
        w_cur_addr = r_cur_addr;
        w_cur_data = r_cur_data;
        w_cur_vld  = r_cur_vld;
        w_rom_addr = r_rom_addr;
        w_rom_cs   = r_rom_cs;
        w_guard    = (r_guard != '0) ? r_guard - GW'(1) : r_guard;
        w_miss     = 1'b0;
`ifdef JTFLANE_PCM_PREFETCH_EN
        w_pre_addr = r_pre_addr;
        w_pre_data = r_pre_data;
        w_pre_vld  = r_pre_vld;
`endif

        case (r_state)
            StIdle: begin
                if (bus.pcm_rd && !w_hit_cur) begin
`ifdef JTFLANE_PCM_PREFETCH_EN
                    if (r_pre_vld && (bus.pcm_addr == r_pre_addr)) begin
                        w_cur_addr = r_pre_addr;
                        w_cur_data = r_pre_data;
                        w_cur_vld  = 1'b1;
                        w_pre_vld  = 1'b0;
                        w_rom_addr = r_pre_addr + AW'(1);
                        w_rom_cs   = 1'b1;
                        w_guard    = GLOAD;
                        w_state    = StPref;
                    end else begin
                        w_miss = 1'b1;
                    end
`else
                    w_miss = 1'b1;
`endif
                end
            end

            StFetch: begin
                if (bus.pcm_rd && (bus.pcm_addr != r_rom_addr)) begin
                    w_miss = 1'b1;
                end else if (w_ok) begin
                    w_cur_data = bus.rom_data;
                    w_cur_vld  = 1'b1;
`ifdef JTFLANE_PCM_PREFETCH_EN
                    w_rom_addr = r_rom_addr + AW'(1);
                    w_guard    = GLOAD;
                    w_state    = StPref;
`else
                    w_rom_cs   = 1'b0;
                    w_state    = StIdle;
`endif
                end
            end

`ifdef JTFLANE_PCM_PREFETCH_EN
            StPref: begin
                if (bus.pcm_rd && !w_hit_cur) begin
                    if (bus.pcm_addr != r_rom_addr) begin
                        w_miss = 1'b1;
                    end else if (w_ok) begin
                        // requested byte arrives this cycle: serve it and prefetch the next one
                        w_cur_addr = bus.pcm_addr;
                        w_cur_data = bus.rom_data;
                        w_cur_vld  = 1'b1;
                        w_rom_addr = bus.pcm_addr + AW'(1);
                        w_guard    = GLOAD;
                    end else begin
                        // keep the in-flight access and its guard progress
                        w_cur_addr = bus.pcm_addr;
                        w_cur_vld  = 1'b0;
                        w_state    = StFetch;
                    end
                end else if (w_ok) begin
                    w_pre_addr = r_rom_addr;
                    w_pre_data = bus.rom_data;
                    w_pre_vld  = 1'b1;
                    w_rom_cs   = 1'b0;
                    w_state    = StIdle;
                end
            end
`endif

            default: begin
                w_rom_cs = 1'b0;
                w_state  = StIdle;
            end
        endcase

        if (w_miss) begin
            w_cur_addr = bus.pcm_addr;
            w_cur_vld  = 1'b0;
            w_rom_addr = bus.pcm_addr;
            w_rom_cs   = 1'b1;
            w_guard    = GLOAD;
            w_state    = StFetch;
`ifdef JTFLANE_PCM_PREFETCH_EN
            w_pre_vld  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cur_addr <= '0;
            r_cur_data <= '0;
            r_cur_vld  <= 1'b0;
            r_rom_addr <= '0;
            r_rom_cs   <= 1'b0;
            r_guard    <= '0;
`ifdef JTFLANE_PCM_PREFETCH_EN
            r_pre_addr <= '0;
            r_pre_data <= '0;
            r_pre_vld  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_cur_addr <= w_cur_addr;
            r_cur_data <= w_cur_data;
            r_cur_vld  <= w_cur_vld;
            r_rom_addr <= w_rom_addr;
            r_rom_cs   <= w_rom_cs;
            r_guard    <= w_guard;
`ifdef JTFLANE_PCM_PREFETCH_EN
            r_pre_addr <= w_pre_addr;
            r_pre_data <= w_pre_data;
            r_pre_vld  <= w_pre_vld;
`endif
        end
    end

    assign bus.pcm_dout  = r_cur_data;
    assign bus.pcm_valid = r_cur_vld;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.rom_cs    = r_rom_cs;
endmodule
